// File: rtl/ahb_interconnect_n.sv
// -----------------------------------------------------------------------------
// ahb_interconnect_n
//
// Single-master AHB-Lite interconnect fanning one master port out to
// NUM_SLAVES slaves.
//
// Address phase
//   The master address is decoded against per-slave (BASE, MASK) regions. The
//   lowest-index matching region wins. hsel is driven combinationally and only
//   for a real (NONSEQ/SEQ) transfer that is being accepted, which means
//   hready=1.
//
// Data phase
//   The owner of the data phase is registered when the address phase is
//   accepted. The owner is one of three things:
//   - a slave index,
//   - the built-in default slave (unmapped address, two-cycle ERROR),
//   - nobody (IDLE/BUSY, zero-wait OKAY).
//   The master-side hrdata/hready/hresp are muxed from the owning slave
//   through that registered select.
//
// Watchdog
//   A per-transfer wait counter forces a two-cycle ERROR if the owning slave
//   stalls for TIMEOUT_CYCLES cycles. The stalled slave is abandoned: its
//   later responses are ignored. TIMEOUT_CYCLES=0 disables the watchdog.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   haddr/htrans/hwrite/hsize/  master address-phase and control inputs
//   hprot/is_signed/hwdata
//   hrdata/hready/hresp         response to the master
//   hsel                        one-hot slave select (address phase)
//   Haddr/Hwrite/Hsize/Hprot/   combinational broadcast to every slave
//   Hwdata/Is_signed
//   s_hrdata/s_hready/s_hresp   flattened slave responses
//   timeout_err                 one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module ahb_interconnect_n #(
    parameter int NUM_SLAVES     = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,

    // Master side
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    input  logic                         hwrite,
    input  logic [2:0]                   hsize,
    input  logic [3:0]                   hprot,
    input  logic                         is_signed,
    input  logic [DATA_W-1:0]            hwdata,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,

    // Slave side
    output logic [NUM_SLAVES-1:0]        hsel,
    output logic [ADDR_W-1:0]            Haddr,
    output logic                         Hwrite,
    output logic [2:0]                   Hsize,
    output logic [3:0]                   Hprot,
    output logic [DATA_W-1:0]            Hwdata,
    output logic                         Is_signed,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_hrdata,
    input  logic [NUM_SLAVES-1:0]        s_hready,
    input  logic [NUM_SLAVES-1:0]        s_hresp,

    output logic                         timeout_err
);

    // -------------------------------------------------------------------------
    // Derived widths
    // -------------------------------------------------------------------------
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // The counter only has to reach TIMEOUT_CYCLES. With the watchdog off it
    // still needs at least one bit so that the declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Count value at which a further stalled cycle trips the watchdog.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_SLAVE = 2'd1,
        D_ERR1  = 2'd2,
        D_ERR2  = 2'd3
    } dstate_t;

    // -------------------------------------------------------------------------
    // Broadcast of master signals to all slaves
    // -------------------------------------------------------------------------
    assign Haddr     = haddr;
    assign Hwrite    = hwrite;
    assign Hsize     = hsize;
    assign Hprot     = hprot;
    assign Hwdata    = hwdata;
    assign Is_signed = is_signed;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [NUM_SLAVES-1:0] region_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_region
            assign region_hit[gi] =
                ((haddr & SLAVE_MASK[gi*ADDR_W +: ADDR_W]) == SLAVE_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Priority encode. Scanning from the top down lets the lowest index
    // overwrite any higher one, so overlapping regions resolve to the lowest
    // slave.
    logic             match_any;
    logic [IDX_W-1:0] match_idx;

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    // hsel is gated by reset so that it reads 0 while reset is held, even
    // though the rest of the select path is purely combinational.
    logic addr_take;
    assign addr_take = htrans[1] & hready & match_any & ~reset;

    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_hsel
            assign hsel[gi] = addr_take && (match_idx == IDX_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Data-phase state
    // -------------------------------------------------------------------------
    dstate_t          state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= D_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // The slave that owns the current data phase.
    logic             own_ready;
    logic             own_resp;
    logic [DATA_W-1:0] own_rdata;

    assign own_ready = s_hready[owner_q];
    assign own_resp  = s_hresp[owner_q];
    assign own_rdata = s_hrdata[owner_q*DATA_W +: DATA_W];

    // Next state and master-side response. The counter defaults to zero, so
    // it restarts for every new data phase and only holds a value while the
    // owning slave is stalling.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = '0;
        hready      = 1'b1;
        hresp       = 1'b0;
        hrdata      = '0;
        timeout_err = 1'b0;

        case (state_q)
            D_IDLE: begin
                // Zero-wait OKAY. The defaults already describe this response.
            end

            D_SLAVE: begin
                hready = own_ready;
                hresp  = own_resp;
                hrdata = own_rdata;
                if (!own_ready) begin
                    // The counter saturates instead of wrapping. This matters
                    // only when the watchdog is disabled and waits are
                    // unbounded.
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                    if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        // The watchdog fires. From here on the interconnect
                        // no longer listens to this slave.
                        timeout_err = 1'b1;
                        state_d     = D_ERR1;
                    end
                end
            end

            D_ERR1: begin
                hready  = 1'b0;
                hresp   = 1'b1;
                state_d = D_ERR2;
            end

            D_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end

            default: begin
                state_d = D_IDLE;
            end
        endcase

        // Address-phase acceptance. Whenever the current data phase completes
        // (hready=1), the transfer on the bus becomes the next data phase.
        // This gives back-to-back pipelining with no bubble.
        if (hready) begin
            cnt_d = '0;
            if (!htrans[1]) begin
                state_d = D_IDLE;
            end else if (match_any) begin
                state_d = D_SLAVE;
                owner_d = match_idx;
            end else begin
                state_d = D_ERR1;
            end
        end
    end

endmodule
